// File: rtl/shifter_pkg.sv
// Shared constants for the shifter datapath blocks: default widths,
// normalizer FSM state encoding and normalize-direction codes.
package shifter_pkg;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_normalizer.sv
// Iterative normalizer: shifts the first set bit to MSB (left) or LSB (right), one bit per cycle.
// Latency k+2 cycles start-to-done for k zeros (1 for a zero operand); start is ignored while busy.
module shift_normalizer
  import shifter_pkg::*;
#(
  parameter int WIDTH = shifter_pkg::WIDTH,
  parameter int SHW   = shifter_pkg::SHW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             norm_dir,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [SHW-1:0]   sh,
  output logic             zero
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [SHW-1:0]   sh_q, sh_d;
  logic             dir_q, dir_d;
  logic             zero_q, zero_d;
  logic             tgt;

  assign tgt = (dir_q == DIR_LEFT) ? work_q[WIDTH-1] : work_q[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (in == '0) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (tgt) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // Result registers only move on completion, so they hold across a new start.
  always_comb begin
    work_d = work_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    sh_d   = sh_q;
    zero_d = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d = in;
          dir_d  = norm_dir;
          cnt_d  = '0;
          if (in == '0) begin
            zero_d = 1'b1;
            out_d  = '0;
            sh_d   = '0;
          end
        end
      end
      ST_SCAN: begin
        if (tgt) begin
          out_d  = work_q;
          sh_d   = cnt_q;
          zero_d = 1'b0;
        end else begin
          work_d = (dir_q == DIR_LEFT) ? {work_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, work_q[WIDTH-1:1]};
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q <= '0;
      dir_q  <= 1'b0;
      cnt_q  <= '0;
      out_q  <= '0;
      sh_q   <= '0;
      zero_q <= 1'b0;
    end else begin
      work_q <= work_d;
      dir_q  <= dir_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      sh_q   <= sh_d;
      zero_q <= zero_d;
    end
  end

  assign out  = out_q;
  assign sh   = sh_q;
  assign zero = zero_q;

endmodule
